seg_scan_n: RTL

//  Time-multiplexed driver for an N-digit common-select 7-segment display.
//  - Shows a 4*N-bit hex value, one nibble per digit, on a shared segment bus.
//  - Adds over the fixed 4-digit scanner: parametrised digit count, scan rate and output polarity; per-digit

---
 rtl/seg_scan_n.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_n.sv
// seg_scan_n: time-multiplexed driver for an N-digit common-select 7-segment
// display. Each digit owns a slot of SCAN_DIV clocks; the first BLANK_CYC clocks
// of every slot keep all selects off so the previous digit's pattern cannot
// ghost onto the next one. Values are double-buffered and only swapped at the
// end of a full scan, so a frame never shows a mix of old and new digits.
module seg_scan_n #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEL_ACTIVE_LOW = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   number,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_blank,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     sel,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // XOR masks applied to the final active-high values to get pin polarity
    localparam logic [NUM_DIGITS-1:0] SEL_INV  = {NUM_DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_INV  = {7{SEG_ACTIVE_LOW}};

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || SCAN_DIV < 2 ||
            BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_param_check
            $error("seg_scan_n: illegal NUM_DIGITS/SCAN_DIV/BLANK_CYC combination");
        end
    endgenerate

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_num_act;
    logic [4*NUM_DIGITS-1:0] r_num_pend;
    logic [NUM_DIGITS-1:0]   r_dp_act;
    logic [NUM_DIGITS-1:0]   r_dp_pend;
    logic                    r_pend_flag;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_tick;

    logic                    w_cnt_wrap;
    logic                    w_boundary;
    logic                    w_in_blank;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_upper_zero;   // bit i: active nibbles i..N-1 are all zero
    logic [3:0]              w_nib_cur;
    logic                    w_blank_cur;
    logic [6:0]              w_seg_dec;
    logic [NUM_DIGITS-1:0]   w_sel_hi;
    logic [6:0]              w_seg_hi;
    logic                    w_dp_hi;

    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_boundary = w_cnt_wrap && (r_idx == IDX_LAST);

    // A zero-length dead time would make the compare trivially false, so it is elided
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_in_blank = 1'b0;
        end else begin : g_blank
            assign w_in_blank = (r_cnt < CNT_W'(BLANK_CYC));
        end
    endgenerate

    // Per-digit nibble view and the "everything above me is zero" chain
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib[gi] = r_num_act[4*gi +: 4];
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign w_upper_zero[gi] = (w_nib[gi] == 4'h0);
            end else begin : g_lower
                assign w_upper_zero[gi] = (w_nib[gi] == 4'h0) && w_upper_zero[gi+1];
            end
        end
    endgenerate

    assign w_nib_cur   = w_nib[r_idx];
    // Digit 0 always shows something, even for a value of zero
    assign w_blank_cur = lz_blank && (r_idx != '0) && w_upper_zero[r_idx];

    // Hex to active-high gfedcba segment pattern
    always_comb begin
        w_seg_dec = 7'h00;
        case (w_nib_cur)
            4'h0: w_seg_dec = 7'h3F;
            4'h1: w_seg_dec = 7'h06;
            4'h2: w_seg_dec = 7'h5B;
            4'h3: w_seg_dec = 7'h4F;
            4'h4: w_seg_dec = 7'h66;
            4'h5: w_seg_dec = 7'h6D;
            4'h6: w_seg_dec = 7'h7D;
            4'h7: w_seg_dec = 7'h07;
            4'h8: w_seg_dec = 7'h7F;
            4'h9: w_seg_dec = 7'h6F;
            4'hA: w_seg_dec = 7'h77;
            4'hB: w_seg_dec = 7'h7C;
            4'hC: w_seg_dec = 7'h39;
            4'hD: w_seg_dec = 7'h5E;
            4'hE: w_seg_dec = 7'h79;
            default: w_seg_dec = 7'h71;
        endcase
    end

    // Active-high pin values for the current (cnt, idx); dark during dead time or disabled digit
    always_comb begin
        w_sel_hi = '0;
        w_seg_hi = 7'h00;
        w_dp_hi  = 1'b0;
        if (!w_in_blank && digit_en[r_idx]) begin
            w_sel_hi = NUM_DIGITS'(1) << r_idx;
            w_seg_hi = w_blank_cur ? 7'h00 : w_seg_dec;
            w_dp_hi  = r_dp_act[r_idx];
        end
    end

    // Slot counter and digit index; the scan rate never depends on the inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Double buffer: loads land in pending, pending moves to active only at a frame boundary;
    // a load coinciding with the boundary bypasses pending so it is not delayed a whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_act   <= '0;
            r_dp_act    <= '0;
            r_num_pend  <= '0;
            r_dp_pend   <= '0;
            r_pend_flag <= 1'b0;
        end else if (w_boundary) begin
            if (load) begin
                r_num_act <= number;
                r_dp_act  <= dp_in;
            end else if (r_pend_flag) begin
                r_num_act <= r_num_pend;
                r_dp_act  <= r_dp_pend;
            end
            r_pend_flag <= 1'b0;
        end else if (load) begin
            r_num_pend  <= number;
            r_dp_pend   <= dp_in;
            r_pend_flag <= 1'b1;
        end
    end

    // Registered pins with polarity applied last, plus the end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= SEL_INV;
            r_seg        <= SEG_INV;
            r_dp         <= SEG_ACTIVE_LOW;
            r_frame_tick <= 1'b0;
        end else begin
            r_sel        <= w_sel_hi ^ SEL_INV;
            r_seg        <= w_seg_hi ^ SEG_INV;
            r_dp         <= w_dp_hi ^ SEG_ACTIVE_LOW;
            r_frame_tick <= w_boundary;
        end
    end

    assign sel        = r_sel;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
